// File: rtl/cam_ctrl_if.sv
// Lookup/learn/flush handshake between a requester and cam_ctrl.
// master = requester side, slave = cam_ctrl side.
interface cam_ctrl_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic          lk_req;
   logic [DW-1:0] lk_data;
   logic          lk_ack;
   logic          lk_hit;
   logic [AW-1:0] lk_idx;

   logic          ln_req;
   logic [DW-1:0] ln_data;
   logic          ln_ack;
   logic          ln_hit;
   logic          ln_full;
   logic [AW-1:0] ln_idx;

   logic          flush;

   modport master (
      output lk_req, lk_data, ln_req, ln_data, flush,
      input  lk_ack, lk_hit, lk_idx, ln_ack, ln_hit, ln_full, ln_idx
   );

   modport slave (
      input  lk_req, lk_data, ln_req, ln_data, flush,
      output lk_ack, lk_hit, lk_idx, ln_ack, ln_hit, ln_full, ln_idx
   );
endinterface

// File: rtl/cam_ctrl.sv
// CAM lookup/learn sequencer: searches the CAM, appends learn misses at wr_ptr,
// services flush. Define CAM_CTRL_RR_EN for round-robin lookup/learn arbitration
// (default build: learn always wins a tie).
//
// state  | meaning
// IDLE   | sample pending flush, then requests
// SEARCH | CAM search driven with the granted key
// CHECK  | CAM result valid, decide outcome
// WRITE  | learn miss: key written at wr_ptr
// RESP   | one-cycle ack, results valid
// FLUSH  | CAM reset pulse, table emptied
module cam_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 5,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   cam_ctrl_if.slave     req_if,
   output logic          cam_enable,
   output logic          cam_write,
   output logic          cam_rst_n,
   output logic [AW-1:0] cam_addr,
   output logic [DW-1:0] cam_data,
   input  logic [AW-1:0] cam_out,
   input  logic          cam_found,
   output logic          busy,
   output logic [AW:0]   count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEARCH = 3'd1,
      CHECK  = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4,
      FLUSH  = 3'd5
   } state_t;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH-1);

   state_t        state;
   logic          grant_ln;
   logic          flush_pend;
   logic [AW-1:0] wr_ptr;
   logic [DW-1:0] key;
   logic          pick_ln;

   always_comb begin
`ifdef CAM_CTRL_RR_EN
      pick_ln = req_if.ln_req && (!req_if.lk_req || !grant_ln);
`else
      pick_ln = req_if.ln_req;
`endif
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         grant_ln       <= 1'b0;
         flush_pend     <= 1'b0;
         wr_ptr         <= '0;
         count          <= '0;
         key            <= '0;
         cam_enable     <= 1'b0;
         cam_write      <= 1'b0;
         cam_rst_n      <= 1'b1;
         cam_addr       <= '0;
         cam_data       <= '0;
         req_if.lk_ack  <= 1'b0;
         req_if.lk_hit  <= 1'b0;
         req_if.lk_idx  <= '0;
         req_if.ln_ack  <= 1'b0;
         req_if.ln_hit  <= 1'b0;
         req_if.ln_full <= 1'b0;
         req_if.ln_idx  <= '0;
      end else begin
         req_if.lk_ack <= 1'b0;
         req_if.ln_ack <= 1'b0;
         cam_enable    <= 1'b0;
         cam_write     <= 1'b0;
         cam_rst_n     <= 1'b1;
         if (req_if.flush) begin
            flush_pend <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (flush_pend || req_if.flush) begin
                  flush_pend <= 1'b0;
                  cam_rst_n  <= 1'b0;
                  count      <= '0;
                  wr_ptr     <= '0;
                  state      <= FLUSH;
               end else if (req_if.lk_req || req_if.ln_req) begin
                  grant_ln   <= pick_ln;
                  key        <= pick_ln ? req_if.ln_data : req_if.lk_data;
                  cam_data   <= pick_ln ? req_if.ln_data : req_if.lk_data;
                  cam_enable <= 1'b1;
                  state      <= SEARCH;
               end
            end

            SEARCH: begin
               state <= CHECK;
            end

            CHECK: begin
               if (!grant_ln) begin
                  req_if.lk_ack <= 1'b1;
                  req_if.lk_hit <= cam_found;
                  req_if.lk_idx <= cam_out;
                  state         <= RESP;
               end else if (cam_found) begin
                  req_if.ln_ack  <= 1'b1;
                  req_if.ln_hit  <= 1'b1;
                  req_if.ln_full <= 1'b0;
                  req_if.ln_idx  <= cam_out;
                  state          <= RESP;
               end else if (count == CNT_FULL) begin
                  // table full: report without touching the CAM, ln_idx keeps its value
                  req_if.ln_ack  <= 1'b1;
                  req_if.ln_hit  <= 1'b0;
                  req_if.ln_full <= 1'b1;
                  state          <= RESP;
               end else begin
                  cam_enable <= 1'b1;
                  cam_write  <= 1'b1;
                  cam_addr   <= wr_ptr;
                  cam_data   <= key;
                  wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                  count      <= count + 1'b1;
                  state      <= WRITE;
               end
            end

            WRITE: begin
               req_if.ln_ack  <= 1'b1;
               req_if.ln_hit  <= 1'b0;
               req_if.ln_full <= 1'b0;
               req_if.ln_idx  <= cam_addr;
               state          <= RESP;
            end

            RESP: begin
               state <= IDLE;
            end

            FLUSH: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural CAM and a key->index table model.
module tb_cam_ctrl;
   localparam int DEPTH = 16;
   localparam int AW    = 5;
   localparam int DW    = 8;
`ifdef CAM_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cam_enable, cam_write, cam_rst_n;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_data;
   logic [AW-1:0] cam_out = '0;
   logic          cam_found = 1'b0;
   logic          busy;
   logic [AW:0]   count;

   always #5 clk = ~clk;

   cam_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   cam_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_if     (bus),
      .cam_enable (cam_enable),
      .cam_write  (cam_write),
      .cam_rst_n  (cam_rst_n),
      .cam_addr   (cam_addr),
      .cam_data   (cam_data),
      .cam_out    (cam_out),
      .cam_found  (cam_found),
      .busy       (busy),
      .count      (count)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // behavioural CAM: search result registered, valid the cycle after the search
   logic [DW-1:0] cam_key [DEPTH];
   bit            cam_vld [DEPTH];
   int            cam_writes = 0;
   int            cam_flushes = 0;

   always @(posedge clk) begin : cam_model
      int m;
      if (!cam_rst_n) begin
         for (int i = 0; i < DEPTH; i++) cam_vld[i] <= 1'b0;
         cam_flushes <= cam_flushes + 1;
      end else if (cam_enable && cam_write) begin
         cam_key[int'(cam_addr) % DEPTH] <= cam_data;
         cam_vld[int'(cam_addr) % DEPTH] <= 1'b1;
         cam_writes <= cam_writes + 1;
      end else if (cam_enable) begin
         m = -1;
         for (int i = DEPTH - 1; i >= 0; i--)
            if (cam_vld[i] && cam_key[i] == cam_data) m = i;
         cam_found <= (m >= 0);
         cam_out   <= (m >= 0) ? AW'(m) : '0;
      end
   end

   // reference model: table of learned keys
   typedef struct {
      bit is_ln;
      bit hit;
      bit full;
      bit chk_idx;
      int idx;
      int cnt;
      int lat;
      int writes;
   } exp_t;

   exp_t sbq[$];
   int   m_tab[int];
   int   m_count = 0;
   int   m_wr_ptr = 0;
   int   m_writes = 0;
   bit   m_last_ln = 1'b0;

   function automatic exp_t model_op(input bit is_ln, input int key);
      exp_t e;
      e.is_ln = is_ln; e.hit = 1'b0; e.full = 1'b0; e.chk_idx = 1'b0;
      e.idx = 0; e.lat = 3;
      m_last_ln = is_ln;
      if (m_tab.exists(key)) begin
         e.hit = 1'b1; e.idx = m_tab[key]; e.chk_idx = 1'b1;
      end else if (is_ln && m_count == DEPTH) begin
         e.full = 1'b1;
      end else if (is_ln) begin
         m_tab[key] = m_wr_ptr;
         e.idx = m_wr_ptr; e.chk_idx = 1'b1; e.lat = 4;
         m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
         m_count++;
         m_writes++;
      end
      e.cnt = m_count;
      e.writes = m_writes;
      return e;
   endfunction

   function automatic void model_clear();
      m_tab.delete();
      m_count = 0;
      m_wr_ptr = 0;
   endfunction

   // monitor: pops one expectation per ack
   initial begin : monitor
      exp_t e;
      int   start;
      bit   pbusy;
      start = 0;
      pbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pbusy = 1'b0;
         end else begin
            if (busy && !pbusy) start = cyc;
            pbusy = busy;
            if (bus.lk_ack || bus.ln_ack) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_ack", int'(bus.lk_ack) + int'(bus.ln_ack), 0);
               end else begin
                  e = sbq.pop_front();
                  chk("ack_kind", int'(bus.ln_ack), int'(e.is_ln));
                  chk("one_ack", int'(bus.lk_ack & bus.ln_ack), 0);
                  if (e.is_ln) begin
                     chk("ln_hit", int'(bus.ln_hit), int'(e.hit));
                     chk("ln_full", int'(bus.ln_full), int'(e.full));
                     if (e.chk_idx) chk("ln_idx", int'(bus.ln_idx), e.idx);
                     chk("cam_writes", cam_writes, e.writes);
                  end else begin
                     chk("lk_hit", int'(bus.lk_hit), int'(e.hit));
                     if (e.chk_idx) chk("lk_idx", int'(bus.lk_idx), e.idx);
                  end
                  chk("count", int'(count), e.cnt);
                  chk("latency", cyc - start + 1, e.lat);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 50);
      if (busy) fail_now("idle_timeout");
   endtask

   task automatic wait_any_ack(output int which);
      which = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         bus.flush = 1'b0;
         if (bus.ln_ack) begin which = 1; break; end
         if (bus.lk_ack) begin which = 0; break; end
      end
      if (which < 0) begin
         fail_now("ack_timeout");
         sbq.delete();
      end
   endtask

   task automatic single(input bit is_ln, input int key);
      int which;
      wait_idle();
      sbq.push_back(model_op(is_ln, key));
      if (is_ln) begin bus.ln_data = DW'(key); bus.ln_req = 1'b1; end
      else       begin bus.lk_data = DW'(key); bus.lk_req = 1'b1; end
      wait_any_ack(which);
      bus.ln_req = 1'b0;
      bus.lk_req = 1'b0;
   endtask

   task automatic pair(input int lk_key, input int ln_key);
      int which, which2;
      bit first_ln;
      wait_idle();
      first_ln = RR ? !m_last_ln : 1'b1;
      if (first_ln) begin
         sbq.push_back(model_op(1'b1, ln_key));
         sbq.push_back(model_op(1'b0, lk_key));
      end else begin
         sbq.push_back(model_op(1'b0, lk_key));
         sbq.push_back(model_op(1'b1, ln_key));
      end
      bus.lk_data = DW'(lk_key); bus.ln_data = DW'(ln_key);
      bus.lk_req = 1'b1; bus.ln_req = 1'b1;
      wait_any_ack(which);
      chk("pair_first_is_learn", which, int'(first_ln));
      if (which == 1) bus.ln_req = 1'b0;
      else if (which == 0) bus.lk_req = 1'b0;
      if (which >= 0) begin
         wait_any_ack(which2);
         chk("pair_second_is_learn", which2, int'(!first_ln));
      end
      bus.lk_req = 1'b0;
      bus.ln_req = 1'b0;
   endtask

   task automatic do_flush();
      wait_idle();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      model_clear();
      wait_idle();
      chk("flush_count", int'(count), 0);
   endtask

   task automatic flush_in_write(input int key);
      int which, f0, n;
      wait_idle();
      f0 = cam_flushes;
      sbq.push_back(model_op(1'b1, key));
      bus.ln_data = DW'(key);
      bus.ln_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cam_write && n < 10);
      chk("write_pulse_seen", int'(cam_write), 1);
      bus.flush = 1'b1;
      wait_any_ack(which);
      bus.ln_req = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      wait_idle();
      chk("flush_after_write", cam_flushes - f0, 1);
      chk("count_after_flush", int'(count), 0);
   endtask

   task automatic mid_reset();
      int w0;
      do_flush();
      w0 = cam_writes;
      bus.ln_data = 8'hE5;
      bus.ln_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_cam_write", int'(cam_write), 0);
      chk("midrst_cam_enable", int'(cam_enable), 0);
      chk("midrst_ln_ack", int'(bus.ln_ack), 0);
      bus.ln_req = 1'b0;
      model_clear();
      m_last_ln = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_no_write", cam_writes - w0, 0);
      chk("midrst_count", int'(count), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int r;
      bus.lk_req = 1'b0; bus.ln_req = 1'b0;
      bus.lk_data = '0;  bus.ln_data = '0;
      bus.flush = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_lk_ack", int'(bus.lk_ack), 0);
      chk("rst_ln_ack", int'(bus.ln_ack), 0);
      chk("rst_lk_hit", int'(bus.lk_hit), 0);
      chk("rst_ln_hit", int'(bus.ln_hit), 0);
      chk("rst_ln_full", int'(bus.ln_full), 0);
      chk("rst_lk_idx", int'(bus.lk_idx), 0);
      chk("rst_ln_idx", int'(bus.ln_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_cam_enable", int'(cam_enable), 0);
      chk("rst_cam_write", int'(cam_write), 0);
      chk("rst_cam_rst_n", int'(cam_rst_n), 1);
      chk("rst_cam_addr", int'(cam_addr), 0);
      chk("rst_cam_data", int'(cam_data), 0);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) single(1'b1, 8'h10 + k);
      single(1'b0, 8'h11);
      single(1'b0, 8'h55);
      single(1'b1, 8'h11);

      do_flush();
      for (int k = 0; k < 16; k++) single(1'b1, 8'h20 + k);
      single(1'b1, 8'hAA);

      do_flush();
      pair(8'h31, 8'h31);
      pair(8'h32, 8'h32);

      do_flush();
      single(1'b1, 8'h10);
      flush_in_write(8'h77);
      single(1'b0, 8'h10);

      for (int k = 0; k < 200; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 4)       do_flush();
         else if (r < 16) pair(int'($urandom_range(0, 47)), int'($urandom_range(0, 47)));
         else             single(1'($urandom_range(0, 1)), int'($urandom_range(0, 47)));
      end

      mid_reset();
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
